hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard and stall controller for the 5-stage pipeline. It generalises the fixed bypass-select logic to cover multi-cycle functional units (mult, div, future FP), of which there can be NUM_UNITS. It keeps a per-register pending table and per-unit busy/destination slots, and raises a single stall to freeze PC and the FD latch. It sits beside decode: it reads the FD instruction fields and the DX load status, and receives completion pulses from each multi-cycle unit.

Parameters:
REG_AW, 5, register address width (2**REG_AW architectural registers; register 0 is never tracked)
NUM_UNITS, 2, number of multi-cycle units (unit index 0..NUM_UNITS-1)
UNIT_IW, 1, width of unit index (must hold NUM_UNITS-1)
CNT_W, 16, width of per-unit busy-cycle counter and of the stall counter

Ports:
clock  in  1  master clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
fd_valid  in  1  FD holds a real (non-bubble) instruction
fd_rs1  in  REG_AW  source A register
fd_rs2  in  REG_AW  source B register
fd_rd  in  REG_AW  destination register
fd_rd_we  in  1  FD instruction writes fd_rd
fd_multi  in  1  FD instruction issues to a multi-cycle unit
fd_unit  in  UNIT_IW  target unit index when fd_multi=1
dx_is_load  in  1  DX instruction is lw
dx_rd  in  REG_AW  DX destination register
flush  in  1  squash the FD instruction this cycle (jump/jr redirect)
unit_done  in  NUM_UNITS  one-cycle completion pulse per unit
stall  out  1  freeze PC and FD; insert bubble into DX
stall_cause  out  2  0 none, 1 load-use, 2 RAW-pending, 3 structural/WAW
issue  out  1  fd_valid & ~stall & ~flush
unit_busy  out  NUM_UNITS  registered busy per unit
unit_rd  out  NUM_UNITS*REG_AW  recorded destination per unit (unit u at [u*REG_AW +: REG_AW])
unit_cycles  out  NUM_UNITS*CNT_W  cycles since issue for each busy unit
stall_count  out  CNT_W  saturating count of stalled cycles
sb_error  out  1  sticky: unit_done seen for an idle unit

Behaviour:
- Reset (reset=0, async): pending table cleared, all unit_busy=0, unit_rd=0, unit_cycles=0, stall_count=0, sb_error=0. Combinational outputs follow from the cleared state, so stall=0 with fd_valid=0.
- A source rs "hits" when rs!=0 and pending[rs]=1.
- stall=0 whenever fd_valid=0 or flush=1.
- Otherwise stall is raised, with the first matching cause taking priority:
  - cause 1: dx_is_load & dx_rd!=0 & (dx_rd==fd_rs1 | dx_rd==fd_rs2).
  - cause 2: hit on fd_rs1 or fd_rs2.
  - cause 3: either of the following:
    - fd_multi & unit_busy[fd_unit];
    - fd_rd_we & fd_rd!=0 & pending[fd_rd] (WAW against an in-flight multi-cycle result).
- stall and stall_cause are purely combinational from inputs and registered state. Latency of a stall decision is 0 cycles.
- On issue with fd_multi=1, at the next edge:
  - unit_busy[fd_unit]<=1 and unit_rd[fd_unit]<=fd_rd;
  - unit_cycles[fd_unit]<=0;
  - if fd_rd_we & fd_rd!=0, pending[fd_rd]<=1.
- Single-cycle issues never set pending; the existing bypass network covers them.
- While a unit is busy, unit_cycles increments every cycle and saturates at all-ones.
- unit_done[u] with unit_busy[u]=1: at the next edge unit_busy[u]<=0 and pending[unit_rd[u]]<=0 (the index-0 entry is a no-op). unit_cycles[u] holds its final value until the next issue.
- unit_done[u] with unit_busy[u]=0: ignored, and sb_error<=1. sb_error clears only on reset.
- Completion in the same cycle as a dependent FD instruction: stall uses the registered pending bit, so the consumer stalls that cycle and issues the next cycle. There is no same-cycle wakeup.
- Completion and a new issue to the same unit in the same cycle cannot occur, because busy blocks the issue. A unit is reusable one cycle after its done pulse.
- Completion of unit u clearing pending[r] while an issue to unit v sets pending[r] in the same cycle cannot occur, because WAW stalls that issue.
- Multiple unit_done bits may assert in the same cycle; all are processed.
- flush does not affect in-flight units or the pending table.
- stall_count increments on every cycle with stall=1 and saturates.

Decomposition:
- Shared package (processor-wide constants): stall-cause encodings CAUSE_NONE=0, CAUSE_LOAD_USE=1, CAUSE_RAW=2, CAUSE_STRUCT=3, and the register-0 constant.
- Sub-module scoreboard_unit_slot, instantiated NUM_UNITS times: busy flag, recorded rd, saturating cycle counter, and the done-while-idle error strobe.
- The top level holds the pending table, the stall/priority logic and stall_count.

Test Plan:
- Reset then idle: reset low mid-run with unit 0 busy -> unit_busy=0, stall=0, stall_count=0 immediately; no pending bits after reset rises.
- Load-use: dx_is_load=1, dx_rd=5; FD add with rs1=5 -> stall=1, cause=1. Same case with dx_rd=0 -> stall=0.
- RAW on multi-cycle result: issue mul r7 on unit 0; next FD reads r7 -> stall cause=2 until unit_done[0] pulses at cycle 33. Consumer issues the cycle after done, and unit_cycles[0] reads 32.
- Structural and WAW:
  - with div busy on unit 1, a second div -> cause=3;
  - with r7 pending, addi r7 -> cause=3;
  - both issue the cycle after done.
- Dual completion: units 0 (rd 3) and 1 (rd 4) done in the same cycle -> both pending bits clear, and both readers issue on the following cycle.
- Error and saturation:
  - unit_done[1] while idle -> sb_error=1, which stays 1 until reset;
  - stall held 2**CNT_W+5 cycles with CNT_W=4 -> stall_count=15.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Processor-wide constants shared by the hazard/stall control logic.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_RAW      = 2'd2,
    CAUSE_STRUCT   = 2'd3
  } stall_cause_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/scoreboard_unit_slot.sv
// One multi-cycle unit slot: busy flag, recorded destination and a
// saturating busy-cycle counter.
module scoreboard_unit_slot #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_en,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              done,
  output logic              busy,
  output logic [REG_AW-1:0] rd,
  output logic [CNT_W-1:0]  cycles,
  output logic              done_ok,
  output logic              done_err
);

  // rd and cycles are kept after completion so the final values stay visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      rd     <= '0;
      cycles <= '0;
    end else if (issue_en) begin
      busy   <= 1'b1;
      rd     <= issue_rd;
      cycles <= '0;
    end else if (busy) begin
      if (done) busy <= 1'b0;
      if (cycles != '1) cycles <= cycles + CNT_W'(1);
    end
  end

  assign done_ok  = done & busy;
  assign done_err = done & ~busy;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and stall controller: pending-register table, per-unit slots,
// prioritised stall decision and saturating stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned UNIT_IW   = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fd_valid,
  input  logic [REG_AW-1:0]           fd_rs1,
  input  logic [REG_AW-1:0]           fd_rs2,
  input  logic [REG_AW-1:0]           fd_rd,
  input  logic                        fd_rd_we,
  input  logic                        fd_multi,
  input  logic [UNIT_IW-1:0]          fd_unit,
  input  logic                        dx_is_load,
  input  logic [REG_AW-1:0]           dx_rd,
  input  logic                        flush,
  input  logic [NUM_UNITS-1:0]        unit_done,
  output logic                        stall,
  output logic [1:0]                  stall_cause,
  output logic                        issue,
  output logic [NUM_UNITS-1:0]        unit_busy,
  output logic [NUM_UNITS*REG_AW-1:0] unit_rd,
  output logic [NUM_UNITS*CNT_W-1:0]  unit_cycles,
  output logic [CNT_W-1:0]            stall_count,
  output logic                        sb_error
);

  localparam int unsigned NREG = 2**REG_AW;
  localparam logic [REG_AW-1:0] R0 = REG_AW'(REG_ZERO);

  logic [NREG-1:0]      pending;
  logic [NREG-1:0]      pending_nxt;
  logic [REG_AW-1:0]    slot_rd [NUM_UNITS];
  logic [NUM_UNITS-1:0] done_ok;
  logic [NUM_UNITS-1:0] done_err;
  logic [NUM_UNITS-1:0] issue_en;
  logic                 unit_conflict;
  stall_cause_e         cause;

  always_comb begin
    unit_conflict = 1'b0;
    for (int unsigned u = 0; u < NUM_UNITS; u++)
      if (fd_unit == UNIT_IW'(u) && unit_busy[u]) unit_conflict = 1'b1;

    cause = CAUSE_NONE;
    if (fd_valid && !flush) begin
      if (dx_is_load && dx_rd != R0 && (dx_rd == fd_rs1 || dx_rd == fd_rs2))
        cause = CAUSE_LOAD_USE;
      else if ((fd_rs1 != R0 && pending[fd_rs1]) || (fd_rs2 != R0 && pending[fd_rs2]))
        cause = CAUSE_RAW;
      else if ((fd_multi && unit_conflict) || (fd_rd_we && fd_rd != R0 && pending[fd_rd]))
        cause = CAUSE_STRUCT;
    end
  end

  assign stall       = (cause != CAUSE_NONE);
  assign stall_cause = cause;
  assign issue       = fd_valid & ~stall & ~flush;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_slot
    assign issue_en[u] = issue & fd_multi & (fd_unit == UNIT_IW'(u));

    scoreboard_unit_slot #(
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .issue_en (issue_en[u]),
      .issue_rd (fd_rd),
      .done     (unit_done[u]),
      .busy     (unit_busy[u]),
      .rd       (slot_rd[u]),
      .cycles   (unit_cycles[u*CNT_W +: CNT_W]),
      .done_ok  (done_ok[u]),
      .done_err (done_err[u])
    );

    assign unit_rd[u*REG_AW +: REG_AW] = slot_rd[u];
  end

  // Clears and the set never target the same register: a WAW stall blocks that issue.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned u = 0; u < NUM_UNITS; u++)
      if (done_ok[u]) pending_nxt[slot_rd[u]] = 1'b0;
    if (issue && fd_multi && fd_rd_we && fd_rd != R0)
      pending_nxt[fd_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      stall_count <= '0;
      sb_error    <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (|done_err) sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations queued at drive time,
// drained and compared at the following negative clock edge.
module tb_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       fd_valid = 1'b0;
  logic [4:0] fd_rs1 = '0, fd_rs2 = '0, fd_rd = '0, dx_rd = '0;
  logic       fd_rd_we = 1'b0, fd_multi = 1'b0, dx_is_load = 1'b0, flush = 1'b0;
  logic [0:0] fd_unit = '0;
  logic [1:0] unit_done = '0;

  logic        stall, issue, sb_error;
  logic [1:0]  stall_cause, unit_busy;
  logic [9:0]  unit_rd;
  logic [31:0] unit_cycles;
  logic [15:0] stall_count;

  logic        stall4, issue4, sb_error4;
  logic [1:0]  stall_cause4, unit_busy4;
  logic [9:0]  unit_rd4;
  logic [7:0]  unit_cycles4;
  logic [3:0]  stall_count4;

  always #5 clock = ~clock;

  hazard_scoreboard #(.REG_AW(5), .NUM_UNITS(2), .UNIT_IW(1), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_rd(fd_rd), .fd_rd_we(fd_rd_we), .fd_multi(fd_multi), .fd_unit(fd_unit),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .flush(flush), .unit_done(unit_done),
    .stall(stall), .stall_cause(stall_cause), .issue(issue), .unit_busy(unit_busy),
    .unit_rd(unit_rd), .unit_cycles(unit_cycles), .stall_count(stall_count),
    .sb_error(sb_error)
  );

  hazard_scoreboard #(.REG_AW(5), .NUM_UNITS(2), .UNIT_IW(1), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_rd(fd_rd), .fd_rd_we(fd_rd_we), .fd_multi(fd_multi), .fd_unit(fd_unit),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .flush(flush), .unit_done(unit_done),
    .stall(stall4), .stall_cause(stall_cause4), .issue(issue4), .unit_busy(unit_busy4),
    .unit_rd(unit_rd4), .unit_cycles(unit_cycles4), .stall_count(stall_count4),
    .sb_error(sb_error4)
  );

  typedef enum {S_STALL, S_CAUSE, S_ISSUE, S_BUSY, S_RD, S_CYC0, S_CNT, S_ERR, S_CNT4, S_CYC4} sel_e;
  typedef struct {
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_stalls = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_STALL: return 32'(stall);
      S_CAUSE: return 32'(stall_cause);
      S_ISSUE: return 32'(issue);
      S_BUSY:  return 32'(unit_busy);
      S_RD:    return 32'(unit_rd);
      S_CYC0:  return 32'(unit_cycles[15:0]);
      S_CNT:   return 32'(stall_count);
      S_ERR:   return 32'(sb_error);
      S_CNT4:  return 32'(stall_count4);
      S_CYC4:  return 32'(unit_cycles4[3:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input sel_e s, input logic [31:0] v);
    q.push_back('{s, v});
    if (s == S_STALL && v == 32'd1) model_stalls++;
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] o;
      e = q.pop_front();
      o = observe(e.sel);
      vectors++;
      assert (o === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.sel.name(), o, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    drain();
    @(posedge clock);
    #1;
  endtask

  task automatic fd(input logic v, input logic [4:0] a, input logic [4:0] b,
                    input logic [4:0] d, input logic we, input logic m, input logic u);
    fd_valid = v; fd_rs1 = a; fd_rs2 = b; fd_rd = d;
    fd_rd_we = we; fd_multi = m; fd_unit = u;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    expect_v(S_STALL, 0); expect_v(S_CAUSE, 0); expect_v(S_BUSY, 0);
    expect_v(S_CNT, 0); expect_v(S_ERR, 0); cyc();

    // load-use, flush override, dx_rd=0
    fd(1, 5, 0, 6, 1, 0, 0); dx_is_load = 1; dx_rd = 5;
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 1); expect_v(S_ISSUE, 0); cyc();
    flush = 1;
    expect_v(S_STALL, 0); expect_v(S_CAUSE, 0); expect_v(S_ISSUE, 0); cyc();
    flush = 0; dx_rd = 0;
    expect_v(S_STALL, 0); expect_v(S_ISSUE, 1); cyc();
    fd_valid = 0; dx_is_load = 0;
    expect_v(S_CNT, model_stalls); cyc();

    // RAW on a multi-cycle result
    fd(1, 1, 2, 7, 1, 1, 0);
    expect_v(S_ISSUE, 1); expect_v(S_STALL, 0); cyc();
    fd(1, 7, 0, 8, 1, 0, 0);
    expect_v(S_BUSY, 1); expect_v(S_RD, 7); expect_v(S_CYC0, 0);
    for (int i = 0; i < 31; i++) begin
      expect_v(S_STALL, 1); expect_v(S_CAUSE, 2); cyc();
    end
    unit_done = 2'b01;
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 2); cyc();
    unit_done = 2'b00;
    expect_v(S_ISSUE, 1); expect_v(S_STALL, 0); expect_v(S_BUSY, 0);
    expect_v(S_CYC0, 32); expect_v(S_CYC4, 15); expect_v(S_CNT, model_stalls); cyc();

    // structural conflict on unit 1
    fd(1, 1, 2, 9, 1, 1, 1);
    expect_v(S_ISSUE, 1); cyc();
    fd(1, 1, 2, 10, 1, 1, 1);
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 3); cyc();
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 3); cyc();
    unit_done = 2'b10;
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 3); cyc();
    unit_done = 2'b00;
    expect_v(S_ISSUE, 1); expect_v(S_STALL, 0); expect_v(S_BUSY, 0); cyc();

    // WAW against r10 in flight on unit 1
    fd(1, 1, 2, 10, 1, 0, 0);
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 3); expect_v(S_BUSY, 2);
    expect_v(S_RD, 10 * 32 + 7); cyc();
    unit_done = 2'b10;
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 3); cyc();
    unit_done = 2'b00;
    expect_v(S_ISSUE, 1); expect_v(S_STALL, 0); cyc();

    // dual completion
    fd(1, 1, 2, 3, 1, 1, 0);
    expect_v(S_ISSUE, 1); cyc();
    fd(1, 1, 2, 4, 1, 1, 1);
    expect_v(S_ISSUE, 1); cyc();
    fd(1, 3, 4, 0, 0, 0, 0);
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 2); expect_v(S_BUSY, 3);
    expect_v(S_RD, 4 * 32 + 3); cyc();
    unit_done = 2'b11;
    expect_v(S_STALL, 1); expect_v(S_CAUSE, 2); cyc();
    unit_done = 2'b00;
    expect_v(S_ISSUE, 1); expect_v(S_BUSY, 0); cyc();
    fd(1, 4, 3, 5, 1, 0, 0);
    expect_v(S_ISSUE, 1); expect_v(S_STALL, 0); cyc();

    // done while idle -> sticky error
    fd_valid = 0; unit_done = 2'b10;
    expect_v(S_ERR, 0); cyc();
    unit_done = 2'b00;
    expect_v(S_ERR, 1); cyc();
    expect_v(S_ERR, 1); cyc();

    // stall held 2**4+5 cycles: 4-bit counter pinned at 15
    fd(1, 5, 0, 6, 1, 0, 0); dx_is_load = 1; dx_rd = 5;
    for (int i = 0; i < 21; i++) begin
      expect_v(S_STALL, 1); expect_v(S_CAUSE, 1); cyc();
    end
    dx_is_load = 0; fd_valid = 0;
    expect_v(S_CNT, model_stalls); expect_v(S_CNT4, 15); cyc();

    // asynchronous reset with unit 0 busy
    fd(1, 1, 2, 7, 1, 1, 0);
    expect_v(S_ISSUE, 1); cyc();
    fd_valid = 0;
    expect_v(S_BUSY, 1);
    @(negedge clock);
    drain();
    #2 reset = 1'b0;
    #1;
    model_stalls = 0;
    expect_v(S_BUSY, 0); expect_v(S_STALL, 0); expect_v(S_CNT, 0);
    expect_v(S_ERR, 0); expect_v(S_CNT4, 0); expect_v(S_CYC0, 0);
    drain();
    @(posedge clock);
    #1 reset = 1'b1;
    fd(1, 7, 0, 8, 1, 0, 0);
    expect_v(S_STALL, 0); expect_v(S_ISSUE, 1); expect_v(S_BUSY, 0); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
